// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for a programmable 50%-duty
// clock divider. A new half-period is taken over a valid/ready port and
// applied only at a phase boundary. clkout always parks low when stopped.
//
// Config handshake: a word transfers on any rising edge where
// cfg_valid && cfg_ready. cfg_ready is low while a word is pending. The
// source must hold cfg_half stable until the transfer edge. A zero word
// transfers but is discarded and flagged on cfg_err for one cycle.
`timescale 1ns/1ps

module clk_div_ctrl #(
  parameter int          CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] pend_q;
  logic             pend_v;

  logic accept;
  logic boundary;

  // Handshake qualifiers and the end-of-phase condition.
  always_comb begin
    accept   = cfg_valid && cfg_ready;
    boundary = (count == (half_q - CNT_W'(1)));
  end

  // Status outputs are pure decodes of registered state.
  always_comb begin
    cfg_ready = !pend_v;
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Controller FSM, phase counter and config registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      half_q  <= CNT_W'(DEFAULT_HALF);
      pend_q  <= '0;
      pend_v  <= 1'b0;
      clkout  <= 1'b0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      tick    <= 1'b0;
      cfg_err <= accept && (cfg_half == '0);

      // Accept and apply are mutually exclusive: accept needs pend_v=0,
      // apply needs pend_v=1.
      if (accept && (cfg_half != '0)) begin
        pend_q <= cfg_half;
        pend_v <= 1'b1;
      end

      case (state)
        IDLE: begin
          count  <= '0;
          clkout <= 1'b0;
          if (pend_v) begin
            half_q <= pend_q;
            pend_v <= 1'b0;
          end
          if (en) begin
            state <= RUN;
          end
        end

        RUN, DRAIN: begin
          if ((state == RUN) && !en && !clkout) begin
            // Already low: stop at once, no need to finish the phase.
            state <= IDLE;
            count <= '0;
          end else begin
            if (boundary) begin
              count  <= '0;
              clkout <= ~clkout;
              tick   <= 1'b1;
              if (pend_v) begin
                half_q <= pend_q;
                pend_v <= 1'b0;
              end
            end else begin
              count <= count + CNT_W'(1);
            end
            // Here clkout is high whenever en is low, so the boundary
            // is the falling edge that lets us park.
            if (en) begin
              state <= RUN;
            end else if (boundary) begin
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl with DEFAULT_HALF=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Cycle R is the first cycle in which the controller is in RUN; with half=4,
// clkout is high in R+4..R+7, R+12..R+15, and so on.
`timescale 1ns/1ps

module tb_clk_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clkout;
  logic             tick;
  logic             busy;
  logic [1:0]       state_dbg;

  int n_checks;
  int n_fail;

  clk_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clkout   (clkout),
    .tick     (tick),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    adv(2);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Raise en in IDLE; returns at the falling edge of cycle R.
  task automatic start_run();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_half = '0;
    adv(2);
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL rst_clkout: got %b want 0", clkout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cfg_ready); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", cfg_err); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %b want 1", busy); end
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL run_clk0: got %b want 0", clkout); end
  endtask

  task automatic test_period();
    int  highs;
    int  ticks;
    logic exp_clk;
    logic exp_tick;
    highs = 0;
    ticks = 0;
    for (int o = 1; o < 84; o++) begin
      @(negedge clk);
      exp_clk  = ((o / 4) % 2) == 1;
      exp_tick = (o >= 4) && ((o % 4) == 0);
      n_checks++; if (clkout !== exp_clk) begin n_fail++; $display("FAIL period_clk o=%0d: got %b want %b", o, clkout, exp_clk); end
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL period_tick o=%0d: got %b want %b", o, tick, exp_tick); end
      if (o >= 4) begin
        if (clkout === 1'b1) highs++;
        if (tick === 1'b1) ticks++;
      end
    end
    n_checks++; if (highs != 40) begin n_fail++; $display("FAIL duty_high: got %0d want 40", highs); end
    n_checks++; if (ticks != 20) begin n_fail++; $display("FAIL tick_count: got %0d want 20", ticks); end
  endtask

  task automatic test_reconfig();
    do_reset();
    start_run();
    adv(5);                       // R+5: high phase, count=1
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL recfg_ready_pre: got %b want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_half = 16'd2;
    adv(1);                       // R+6
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL recfg_ready_r6: got %b want 0", cfg_ready); end
    adv(1);                       // R+7
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL recfg_hi_r7: got %b want 1", clkout); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL recfg_ready_r7: got %b want 0", cfg_ready); end
    adv(1);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL recfg_fall_r8: clk=%b tick=%b want 0 1", clkout, tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL recfg_ready_r8: got %b want 1", cfg_ready); end
    adv(1);                       // R+9
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL recfg_r9: clk=%b tick=%b want 0 0", clkout, tick); end
    adv(1);                       // R+10
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL recfg_rise_r10: clk=%b tick=%b want 1 1", clkout, tick); end
    adv(2);                       // R+12
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL recfg_fall_r12: clk=%b tick=%b want 0 1", clkout, tick); end
  endtask

  task automatic test_collision();
    do_reset();
    start_run();
    adv(3);                       // R+3: boundary cycle (count=3)
    cfg_valid = 1'b1; cfg_half = 16'd6;
    adv(1);                       // R+4
    cfg_valid = 1'b0;
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL coll_rise_r4: clk=%b tick=%b want 1 1", clkout, tick); end
    adv(3);                       // R+7
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL coll_hi_r7: got %b want 1", clkout); end
    adv(1);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL coll_fall_r8: clk=%b tick=%b want 0 1", clkout, tick); end
    adv(5);                       // R+13
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL coll_lo_r13: got %b want 0", clkout); end
    adv(1);                       // R+14
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL coll_rise_r14: clk=%b tick=%b want 1 1", clkout, tick); end
    adv(5);                       // R+19
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL coll_hi_r19: got %b want 1", clkout); end
    adv(1);                       // R+20
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL coll_fall_r20: clk=%b tick=%b want 0 1", clkout, tick); end
  endtask

  task automatic test_zero_cfg();
    do_reset();
    start_run();
    adv(1);                       // R+1
    cfg_valid = 1'b1; cfg_half = '0;
    adv(1);                       // R+2
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL zero_err_pulse: got %b want 1", cfg_err); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", cfg_ready); end
    adv(1);                       // R+3
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL zero_err_end: got %b want 0", cfg_err); end
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL zero_lo_r3: got %b want 0", clkout); end
    adv(1);                       // R+4
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL zero_rise_r4: clk=%b tick=%b want 1 1", clkout, tick); end
    adv(4);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL zero_fall_r8: clk=%b tick=%b want 0 1", clkout, tick); end
  endtask

  task automatic test_stop_high();
    do_reset();
    start_run();
    adv(5);                       // R+5: high, count=1
    en = 1'b0;
    adv(1);                       // R+6
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL stophi_drain: got %0d want 2", state_dbg); end
    n_checks++; if (busy !== 1'b1 || clkout !== 1'b1) begin n_fail++; $display("FAIL stophi_r6: busy=%b clk=%b want 1 1", busy, clkout); end
    adv(1);                       // R+7
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL stophi_r7: got %b want 1", clkout); end
    adv(1);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL stophi_fall_r8: clk=%b tick=%b want 0 1", clkout, tick); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stophi_idle_r8: busy=%b want 0", busy); end
    adv(3);                       // R+11
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stophi_park: clk=%b tick=%b busy=%b want 0 0 0", clkout, tick, busy); end
  endtask

  task automatic test_stop_low();
    do_reset();
    start_run();
    adv(1);                       // R+1: low, count=1
    en = 1'b0;
    adv(1);                       // R+2
    n_checks++; if (busy !== 1'b0 || clkout !== 1'b0) begin n_fail++; $display("FAIL stoplo_idle: busy=%b clk=%b want 0 0", busy, clkout); end
    adv(4);                       // R+6
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL stoplo_park: clk=%b tick=%b want 0 0", clkout, tick); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_run();
    adv(5);                       // R+5
    en = 1'b0;
    adv(1);                       // R+6: in DRAIN
    en = 1'b1;
    adv(1);                       // R+7
    n_checks++; if (clkout !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_r7: clk=%b busy=%b want 1 1", clkout, busy); end
    adv(1);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_r8: clk=%b tick=%b busy=%b want 0 1 1", clkout, tick, busy); end
    adv(3);                       // R+11
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL b2b_r11: got %b want 0", clkout); end
    adv(1);                       // R+12
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL b2b_r12: clk=%b tick=%b st=%0d want 1 1 1", clkout, tick, state_dbg); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run();
    adv(5);                       // R+5: high
    cfg_valid = 1'b1; cfg_half = 16'd2;
    adv(1);                       // R+6
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || clkout !== 1'b1) begin n_fail++; $display("FAIL arst_pre: ready=%b clk=%b want 0 1", cfg_ready, clkout); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL arst_clkout: got %b want 0", clkout); end
    n_checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL arst_state: busy=%b ready=%b want 0 1", busy, cfg_ready); end
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_run();
    adv(3);                       // R+3
    n_checks++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL arst_lo_r3: got %b want 0", clkout); end
    adv(1);                       // R+4
    n_checks++; if (clkout !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_rise_r4: clk=%b tick=%b want 1 1", clkout, tick); end
    adv(3);                       // R+7
    n_checks++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL arst_hi_r7: got %b want 1", clkout); end
    adv(1);                       // R+8
    n_checks++; if (clkout !== 1'b0 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_fall_r8: clk=%b tick=%b want 0 1", clkout, tick); end
  endtask

  // Test sequence and final report.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    test_reset();
    test_period();
    test_reconfig();
    test_collision();
    test_zero_cfg();
    test_stop_high();
    test_stop_low();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
